// File: rtl/csr_unit_if.sv
// CSR access bus between the pipeline and the CSR unit: read port plus op/write port.
interface csr_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [11:0]     rd_addr;
    logic [XLEN-1:0] rd_data;
    logic [1:0]      csr_op;
    logic [11:0]     wr_addr;
    logic [XLEN-1:0] wr_src;

    // Pipeline side: issues addresses and ops, receives read data.
    modport master (
        output rd_addr,
        output csr_op,
        output wr_addr,
        output wr_src,
        input  rd_data
    );

    // CSR unit side.
    modport slave (
        input  rd_addr,
        input  csr_op,
        input  wr_addr,
        input  wr_src,
        output rd_data
    );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSRRW/RS/RC access, trap entry and MRET sequencing,
// interrupt-pending tracking and writable cycle/instret counters.
// Legal parameter ranges: XLEN >= 32, 33 <= CNT_W <= 64.
module csr_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     CNT_W     = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    csr_unit_if.slave       bus,
    input  logic            instr_retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_val,
    input  logic            mret,
    input  logic            ext_irq,
    input  logic            tmr_irq,
    input  logic            sw_irq,
    output logic            irq_req,
    output logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] mepc_out,
    output logic            glb_int_en
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [XLEN-1:0] MPP_BITS      = XLEN'(32'h0000_1800);
    localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'(32'h0000_0088);
    localparam logic [XLEN-1:0] MIE_WMASK     = XLEN'(32'h0000_0888);
    localparam logic [XLEN-1:0] MTVEC_WMASK   = ~XLEN'(32'h0000_0002);
    localparam logic [XLEN-1:0] MEPC_WMASK    = ~XLEN'(32'h0000_0003);
    localparam logic [XLEN-1:0] CNT_LO_WMASK  = XLEN'(32'hFFFF_FFFF);
    localparam logic [XLEN-1:0] CNT_HI_WMASK  = XLEN'((64'd1 << (CNT_W - 32)) - 64'd1);

    logic              mstatus_mie;
    logic              mstatus_mpie;
    logic [XLEN-1:0]   mie_q;
    logic [XLEN-1:0]   mip_q;
    logic [XLEN-1:0]   mtvec_q;
    logic [XLEN-1:0]   mepc_q;
    logic [XLEN-1:0]   mcause_q;
    logic [XLEN-1:0]   mtval_q;
    logic [XLEN-1:0]   mscratch_q;
    logic [CNT_W-1:0]  mcycle_q;
    logic [CNT_W-1:0]  minstret_q;

    logic [XLEN-1:0]   wr_old;
    logic [XLEN-1:0]   wr_raw;
    logic [XLEN-1:0]   wr_val;
    logic [XLEN-1:0]   wr_view;
    logic              wr_en;
    logic              rd_fwd;

    // Architectural read view of a CSR address; unmapped addresses read 0.
    function automatic logic [XLEN-1:0] csr_read(input logic [11:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        case (a)
            A_MSTATUS:              v = MPP_BITS | XLEN'({mstatus_mpie, 3'b000, mstatus_mie, 3'b000});
            A_MIE:                  v = mie_q;
            A_MIP:                  v = mip_q;
            A_MTVEC:                v = mtvec_q;
            A_MEPC:                 v = mepc_q;
            A_MCAUSE:               v = mcause_q;
            A_MTVAL:                v = mtval_q;
            A_MSCRATCH:             v = mscratch_q;
            A_MCYCLE, A_CYCLE:      v = XLEN'(mcycle_q[31:0]);
            A_MCYCLEH, A_CYCLEH:    v = XLEN'(mcycle_q[CNT_W-1:32]);
            A_MINSTRET, A_INSTRET:  v = XLEN'(minstret_q[31:0]);
            A_MINSTRETH, A_INSTRETH: v = XLEN'(minstret_q[CNT_W-1:32]);
            default:                v = '0;
        endcase
        return v;
    endfunction

    // Writable-bit mask per address; zero marks a read-only or unmapped address.
    function automatic logic [XLEN-1:0] wr_mask(input logic [11:0] a);
        logic [XLEN-1:0] m;
        m = '0;
        case (a)
            A_MSTATUS:                  m = MSTATUS_WMASK;
            A_MIE:                      m = MIE_WMASK;
            A_MTVEC:                    m = MTVEC_WMASK;
            A_MEPC:                     m = MEPC_WMASK;
            A_MCAUSE, A_MTVAL, A_MSCRATCH: m = '1;
            A_MCYCLE, A_MINSTRET:       m = CNT_LO_WMASK;
            A_MCYCLEH, A_MINSTRETH:     m = CNT_HI_WMASK;
            default:                    m = '0;
        endcase
        return m;
    endfunction

    // Op evaluation, masking, squash by trap/MRET and read-forward detection.
    always_comb begin
        wr_old = csr_read(bus.wr_addr);
        wr_raw = wr_old;
        case (bus.csr_op)
            OP_RW:   wr_raw = bus.wr_src;
            OP_RS:   wr_raw = wr_old | bus.wr_src;
            OP_RC:   wr_raw = wr_old & ~bus.wr_src;
            default: wr_raw = wr_old;
        endcase
        wr_val  = wr_raw & wr_mask(bus.wr_addr);
        wr_view = wr_val | ((bus.wr_addr == A_MSTATUS) ? MPP_BITS : '0);
        wr_en   = (bus.csr_op != OP_NONE) && (wr_mask(bus.wr_addr) != '0)
                  && !trap_valid && !mret;
        // Forward only a write that actually commits, so rd_data matches the next state.
        rd_fwd  = wr_en && (bus.wr_addr == bus.rd_addr);
    end

    // CSR state: trap entry beats MRET beats software write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mtvec_q      <= MTVEC_RST & MTVEC_WMASK;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            mscratch_q   <= '0;
        end else if (trap_valid) begin
            mepc_q       <= {trap_pc[XLEN-1:2], 2'b00};
            mcause_q     <= trap_cause;
            mtval_q      <= trap_val;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (wr_en) begin
            case (bus.wr_addr)
                A_MSTATUS: begin
                    mstatus_mie  <= wr_val[3];
                    mstatus_mpie <= wr_val[7];
                end
                A_MIE:      mie_q      <= wr_val;
                A_MTVEC:    mtvec_q    <= wr_val;
                A_MEPC:     mepc_q     <= wr_val;
                A_MCAUSE:   mcause_q   <= wr_val;
                A_MTVAL:    mtval_q    <= wr_val;
                A_MSCRATCH: mscratch_q <= wr_val;
                default:    ;
            endcase
        end
    end

    // Pending interrupts sampled every cycle from the level sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mip_q <= '0;
        end else begin
            mip_q <= XLEN'({ext_irq, 3'b000, tmr_irq, 3'b000, sw_irq, 3'b000});
        end
    end

    // Counters: a write to either half replaces that cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (wr_en && bus.wr_addr == A_MCYCLE) begin
                mcycle_q <= {mcycle_q[CNT_W-1:32], wr_val[31:0]};
            end else if (wr_en && bus.wr_addr == A_MCYCLEH) begin
                mcycle_q <= {wr_val[CNT_W-33:0], mcycle_q[31:0]};
            end else begin
                mcycle_q <= mcycle_q + CNT_W'(1);
            end

            if (wr_en && bus.wr_addr == A_MINSTRET) begin
                minstret_q <= {minstret_q[CNT_W-1:32], wr_val[31:0]};
            end else if (wr_en && bus.wr_addr == A_MINSTRETH) begin
                minstret_q <= {wr_val[CNT_W-33:0], minstret_q[31:0]};
            end else if (instr_retire) begin
                minstret_q <= minstret_q + CNT_W'(1);
            end
        end
    end

    // Registered read port with same-cycle write forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= rd_fwd ? wr_view : csr_read(bus.rd_addr);
        end
    end

    // Handler address: vectored mode offsets interrupts by 4 * cause.
    always_comb begin
        trap_target = {mtvec_q[XLEN-1:2], 2'b00};
        if (mtvec_q[0] && trap_cause[XLEN-1]) begin
            trap_target = trap_target + XLEN'({trap_cause[4:0], 2'b00});
        end
    end

    assign irq_req    = mstatus_mie & (|(mip_q & mie_q));
    assign glb_int_en = mstatus_mie;
    assign mepc_out   = mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: vector table through a read-data scoreboard,
// plus hand sequences for interrupts, traps, MRET, counters and async reset.
module tb_csr_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
    localparam logic [1:0] N  = 2'b00;
    localparam logic [1:0] RW = 2'b01;
    localparam logic [1:0] RS = 2'b10;
    localparam logic [1:0] RC = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] wa;
        logic [31:0] ws;
        logic [11:0] ra;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        int          tol;
        string       nm;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        instr_retire;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_val;
    logic        mret;
    logic        ext_irq;
    logic        tmr_irq;
    logic        sw_irq;
    logic        irq_req;
    logic [31:0] trap_target;
    logic [31:0] mepc_out;
    logic        glb_int_en;

    int   total;
    int   bad;
    int   cyc;
    sb_t  sb_q[$];
    vec_t vecs[$];

    csr_unit_if #(.XLEN(32)) bus ();

    csr_unit #(
        .XLEN     (32),
        .CNT_W    (64),
        .MTVEC_RST(MTVEC_RST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .instr_retire(instr_retire),
        .trap_valid  (trap_valid),
        .trap_pc     (trap_pc),
        .trap_cause  (trap_cause),
        .trap_val    (trap_val),
        .mret        (mret),
        .ext_irq     (ext_irq),
        .tmr_irq     (tmr_irq),
        .sw_irq      (sw_irq),
        .irq_req     (irq_req),
        .trap_target (trap_target),
        .mepc_out    (mepc_out),
        .glb_int_en  (glb_int_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle count: number of clock edges seen out of reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against rd_data.
    task automatic sb_check();
        sb_t    e;
        longint d;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got 0x%08h expected <none>", bus.rd_data);
        end else begin
            e = sb_q.pop_front();
            d = longint'(bus.rd_data) - longint'(e.exp);
            if ($isunknown(bus.rd_data) || d > longint'(e.tol) || d < -longint'(e.tol)) begin
                bad++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (+/-%0d)",
                         e.nm, bus.rd_data, e.exp, e.tol);
            end
        end
    endtask

    // One clock: drive op/read address, queue the expected rd_data, check after the edge.
    task automatic step(input logic [1:0] op, input logic [11:0] wa, input logic [31:0] ws,
                        input logic [11:0] ra, input logic [31:0] exp, input int tol,
                        input string nm);
        bus.csr_op  = op;
        bus.wr_addr = wa;
        bus.wr_src  = ws;
        bus.rd_addr = ra;
        sb_q.push_back('{exp, tol, nm});
        @(posedge clk);
        #1;
        sb_check();
        bus.csr_op = N;
    endtask

    task automatic rd(input logic [11:0] ra, input logic [31:0] exp, input string nm);
        step(N, 12'h000, 32'h0, ra, exp, 0, nm);
    endtask

    initial begin
        logic [11:0] rst_addr[15];
        logic [31:0] rst_exp[15];

        total = 0;
        bad   = 0;

        vecs.push_back('{RW, 12'h340, 32'hA5A5_0000, 12'h7C0, 32'h0,         "rw_scratch"});
        vecs.push_back('{N,  12'h000, 32'h0,         12'h340, 32'hA5A5_0000, "rd_after_rw"});
        vecs.push_back('{RS, 12'h340, 32'h0000_00FF, 12'h7C0, 32'h0,         "rs_scratch"});
        vecs.push_back('{N,  12'h000, 32'h0,         12'h340, 32'hA5A5_00FF, "rd_after_rs"});
        vecs.push_back('{RC, 12'h340, 32'hA500_0000, 12'h7C0, 32'h0,         "rc_scratch"});
        vecs.push_back('{N,  12'h000, 32'h0,         12'h340, 32'h00A5_00FF, "rd_after_rc"});
        vecs.push_back('{RW, 12'h340, 32'h0000_1234, 12'h340, 32'h0000_1234, "fwd_scratch"});
        vecs.push_back('{RW, 12'h344, 32'hFFFF_FFFF, 12'h344, 32'h0,         "mip_wr_nofwd"});
        vecs.push_back('{N,  12'h000, 32'h0,         12'h344, 32'h0,         "mip_wr_ignored"});
        vecs.push_back('{RW, 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, "mstatus_mask"});
        vecs.push_back('{RW, 12'h300, 32'h0,         12'h300, 32'h0000_1800, "mstatus_clr"});
        vecs.push_back('{RW, 12'h304, 32'hFFFF_FFFF, 12'h7C0, 32'h0,         "mie_wr"});
        vecs.push_back('{N,  12'h000, 32'h0,         12'h304, 32'h0000_0888, "mie_mask"});
        vecs.push_back('{RW, 12'h304, 32'h0,         12'h304, 32'h0,         "mie_clr_fwd"});
        vecs.push_back('{RW, 12'h305, 32'hFFFF_FFFF, 12'h305, 32'hFFFF_FFFD, "mtvec_mask"});
        vecs.push_back('{RW, 12'h341, 32'hFFFF_FFFF, 12'h7C0, 32'h0,         "mepc_wr"});
        vecs.push_back('{N,  12'h000, 32'h0,         12'h341, 32'hFFFF_FFFC, "mepc_mask"});
        vecs.push_back('{RS, 12'h342, 32'hF0F0_F0F0, 12'h7C0, 32'h0,         "mcause_rs"});
        vecs.push_back('{RC, 12'h342, 32'hF000_0000, 12'h342, 32'h00F0_F0F0, "mcause_rc_fwd"});
        vecs.push_back('{RW, 12'h343, 32'hCAFE_BABE, 12'h343, 32'hCAFE_BABE, "mtval_fwd"});
        vecs.push_back('{RW, 12'h7C0, 32'hFFFF_FFFF, 12'h7C0, 32'h0,         "unmapped"});

        rst_addr = '{12'h300, 12'h304, 12'h344, 12'h305, 12'h341, 12'h342, 12'h343, 12'h340,
                     12'hB02, 12'hB82, 12'hC02, 12'hC82, 12'hB80, 12'hC80, 12'h7C0};
        rst_exp  = '{32'h0000_1800, 32'h0, 32'h0, MTVEC_RST, 32'h0, 32'h0, 32'h0, 32'h0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        rst_n        = 1'b0;
        instr_retire = 1'b0;
        trap_valid   = 1'b0;
        trap_pc      = '0;
        trap_cause   = '0;
        trap_val     = '0;
        mret         = 1'b0;
        ext_irq      = 1'b0;
        tmr_irq      = 1'b0;
        sw_irq       = 1'b0;
        bus.csr_op   = N;
        bus.wr_addr  = '0;
        bus.wr_src   = '0;
        bus.rd_addr  = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_mepc_out", mepc_out, 32'h0);
        chk("rst_glb_int_en", 32'(glb_int_en), 32'h0);
        chk("rst_irq_req", 32'(irq_req), 32'h0);
        chk("rst_trap_target", trap_target, MTVEC_RST);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            rd(rst_addr[i], rst_exp[i], $sformatf("rst_read_%03h", rst_addr[i]));
        end

        repeat (200) @(posedge clk);
        #1;
        step(N, 12'h000, 32'h0, 12'hC00, 32'(cyc), 1, "cycle_count");

        // Table-driven CSR operations.
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].op, vecs[i].wa, vecs[i].ws, vecs[i].ra, vecs[i].exp, 0, vecs[i].nm);
        end

        // Interrupt setup: MIE, external enable, vectored mtvec.
        step(RW, 12'h300, 32'h0000_0008, 12'h7C0, 32'h0, 0, "setup_mstatus");
        step(RW, 12'h304, 32'h0000_0800, 12'h7C0, 32'h0, 0, "setup_mie");
        step(RW, 12'h305, 32'h8000_0001, 12'h305, 32'h8000_0001, 0, "setup_mtvec");
        chk("glb_int_en_set", 32'(glb_int_en), 32'h1);
        ext_irq = 1'b1;
        #1;
        chk("irq_req_not_yet", 32'(irq_req), 32'h0);
        rd(12'h344, 32'h0, "mip_sampled_old");
        chk("irq_req_after_1", 32'(irq_req), 32'h1);

        // Trap entry on the external interrupt.
        trap_valid = 1'b1;
        trap_pc    = 32'h0000_1003;
        trap_cause = 32'h8000_000B;
        trap_val   = 32'h0000_0077;
        #1;
        chk("trap_target_vec", trap_target, 32'h8000_002C);
        step(RW, 12'h340, 32'hBAD0_BAD0, 12'h7C0, 32'h0, 0, "trap_squash_wr");
        trap_valid = 1'b0;
        chk("trap_mepc_out", mepc_out, 32'h0000_1000);
        chk("trap_mie_clr", 32'(glb_int_en), 32'h0);
        chk("trap_irq_masked", 32'(irq_req), 32'h0);
        rd(12'h300, 32'h0000_1880, "trap_mstatus");
        rd(12'h342, 32'h8000_000B, "trap_mcause");
        rd(12'h343, 32'h0000_0077, "trap_mtval");
        rd(12'h340, 32'h0000_1234, "trap_scratch_kept");
        chk("mip_live", 32'(irq_req), 32'h0);
        ext_irq = 1'b0;

        // MRET with a same-cycle write that must be squashed.
        mret = 1'b1;
        step(RW, 12'h340, 32'h0000_DEAD, 12'h7C0, 32'h0, 0, "mret_cycle");
        mret = 1'b0;
        chk("mret_mie", 32'(glb_int_en), 32'h1);
        rd(12'h300, 32'h0000_1888, "mret_mstatus");
        rd(12'h340, 32'h0000_1234, "mret_scratch_kept");

        // instret wrap across both halves.
        step(RW, 12'hB82, 32'hFFFF_FFFF, 12'h7C0, 32'h0, 0, "wr_minstreth");
        step(RW, 12'hB02, 32'hFFFF_FFFF, 12'hB82, 32'hFFFF_FFFF, 0, "rd_minstreth");
        instr_retire = 1'b1;
        step(N, 12'h000, 32'h0, 12'hB02, 32'hFFFF_FFFF, 0, "rd_minstret_full");
        instr_retire = 1'b0;
        rd(12'hB02, 32'h0, "wrap_lo");
        rd(12'hB82, 32'h0, "wrap_hi");
        instr_retire = 1'b1;
        step(RW, 12'hB02, 32'h0000_0100, 12'h7C0, 32'h0, 0, "wr_with_retire");
        instr_retire = 1'b0;
        rd(12'hC02, 32'h0000_0100, "retire_no_inc");

        // mcycle write, then an ignored write to the read-only alias.
        step(RW, 12'hB00, 32'h0000_0005, 12'h7C0, 32'h0, 0, "wr_mcycle");
        step(RW, 12'hC00, 32'h0, 12'hB00, 32'h0000_0005, 0, "mcycle_loaded");
        rd(12'hC00, 32'h0000_0006, "cycle_alias_ro");

        // Asynchronous reset mid-cycle.
        rd(12'h300, 32'h0000_1888, "pre_reset_rd");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rd_data", bus.rd_data, 32'h0);
        chk("async_rst_mepc", mepc_out, 32'h0);
        chk("async_rst_mie", 32'(glb_int_en), 32'h0);
        chk("async_rst_target", trap_target, MTVEC_RST);
        @(negedge clk);
        rst_n = 1'b1;
        rd(12'h340, 32'h0, "post_rst_scratch");
        rd(12'h300, 32'h0000_1800, "post_rst_mstatus");
        rd(12'h305, MTVEC_RST, "post_rst_mtvec");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
